// File: rtl/bus_interconnect.sv
// bus_interconnect: decodes the CPU's paired even/odd byte-lane bus into 2..4 regions,
// each with its own wait-state count. Optional unmapped-access detection: `define BUSERR_EN.
module bus_interconnect #(
  parameter int               NREGIONS = 4,
  parameter int               ADDRW    = 15,
  parameter logic [ADDRW-1:0] BASE0    = 15'h0000,
  parameter logic [ADDRW-1:0] BASE1    = 15'h0800,
  parameter logic [ADDRW-1:0] BASE2    = 15'h1000,
  parameter logic [ADDRW-1:0] BASE3    = 15'h1800,
  parameter int               WS0      = 0,
  parameter int               WS1      = 0,
  parameter int               WS2      = 1,
  parameter int               WS3      = 2
`ifdef BUSERR_EN
  , parameter logic [ADDRW-1:0] TOP    = 15'h3000
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic [ADDRW-1:0]      read_addr_even,
  input  logic [ADDRW-1:0]      read_addr_odd,
  input  logic [ADDRW-1:0]      write_addr_even,
  input  logic [ADDRW-1:0]      write_addr_odd,
  input  logic                  write_en_even,
  input  logic                  write_en_odd,
  input  logic [7:0]            write_data_even,
  input  logic [7:0]            write_data_odd,
  output logic [7:0]            read_data_even,
  output logic [7:0]            read_data_odd,
  output logic                  stall,
  output logic [NREGIONS-1:0]   slv_write_en_even,
  output logic [NREGIONS-1:0]   slv_write_en_odd,
  input  logic [8*NREGIONS-1:0] slv_read_data_even,
  input  logic [8*NREGIONS-1:0] slv_read_data_odd
`ifdef BUSERR_EN
  , output logic                bus_error
`endif
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t     state_r, state_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  logic [1:0] sel_r;
  logic       rd_err_r;
  logic       rd_act_s, wr_act_s, rd_map_s, wr_map_s;
  logic [1:0] rd_reg_s, wr_reg_s;
  logic [2:0] rd_ws_s, wr_ws_s, ws_s;
  logic       stall_raw_s, acc_raw_s, accept_s;
  logic [7:0] rd_mux_e_s, rd_mux_o_s;
  logic       unused_s;

  // Addresses and data of both lanes go straight to the slaves; only odd-lane addresses decode.
  assign unused_s = ^{read_addr_even, write_addr_even, write_data_even, write_data_odd};

  // Region index: the highest base not above the address wins.
  function automatic logic [1:0] region_of(input logic [ADDRW-1:0] addr);
    logic [ADDRW-1:0] off;
    off = addr - BASE0;
    if (NREGIONS > 3 && off >= (BASE3 - BASE0)) begin
      return 2'd3;
    end else if (NREGIONS > 2 && off >= (BASE2 - BASE0)) begin
      return 2'd2;
    end else if (off >= (BASE1 - BASE0)) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

  function automatic logic [2:0] ws_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'(WS0);
      2'd1:    return 3'(WS1);
      2'd2:    return 3'(WS2);
      2'd3:    return 3'(WS3);
      default: return 3'd0;
    endcase
  endfunction

  assign rd_act_s = read_req;
  assign wr_act_s = write_en_even | write_en_odd;
  assign rd_reg_s = region_of(read_addr_odd);
  assign wr_reg_s = region_of(write_addr_odd);

`ifdef BUSERR_EN
  assign rd_map_s = (read_addr_odd < TOP);
  assign wr_map_s = (write_addr_odd < TOP);
`else
  assign rd_map_s = 1'b1;
  assign wr_map_s = 1'b1;
`endif

  // Unmapped or inactive sides contribute no wait states.
  assign rd_ws_s = (rd_act_s && rd_map_s) ? ws_of(rd_reg_s) : 3'd0;
  assign wr_ws_s = (wr_act_s && wr_map_s) ? ws_of(wr_reg_s) : 3'd0;
  assign ws_s    = (rd_ws_s > wr_ws_s) ? rd_ws_s : wr_ws_s;

  // Next-state, stall and acceptance.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_raw_s = 1'b0;
    acc_raw_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((rd_act_s || wr_act_s) && ws_s != 3'd0) begin
          stall_raw_s = 1'b1;
          cnt_nxt_s   = ws_s;
          state_nxt_s = ST_WAIT;
        end else begin
          acc_raw_s = rd_act_s | wr_act_s;
        end
      end
      ST_WAIT: begin
        if (cnt_r > 3'd1) begin
          stall_raw_s = 1'b1;
          cnt_nxt_s   = cnt_r - 3'd1;
        end else begin
          acc_raw_s   = 1'b1;
          cnt_nxt_s   = 3'd0;
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // A reset cycle never accepts an access, so no slave sees a write then.
  assign stall    = stall_raw_s & ~reset;
  assign accept_s = acc_raw_s & ~reset;

  // State and wait-state counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Read-data select captured at acceptance; slaves answer one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_r    <= 2'd0;
      rd_err_r <= 1'b0;
    end else if (accept_s && rd_act_s) begin
      sel_r    <= rd_reg_s;
      rd_err_r <= ~rd_map_s;
    end else begin
      sel_r    <= sel_r;
      rd_err_r <= rd_err_r;
    end
  end

  // One-hot slave write enables, only in the accept cycle.
  always_comb begin
    slv_write_en_even = {NREGIONS{1'b0}};
    slv_write_en_odd  = {NREGIONS{1'b0}};
    for (int i = 0; i < NREGIONS; i++) begin
      if (accept_s && wr_map_s && wr_reg_s == 2'(i)) begin
        slv_write_en_even[i] = write_en_even;
        slv_write_en_odd[i]  = write_en_odd;
      end else begin
        slv_write_en_even[i] = 1'b0;
        slv_write_en_odd[i]  = 1'b0;
      end
    end
  end

  // Read-data mux: AND-OR over the region lanes.
  always_comb begin
    rd_mux_e_s = 8'h00;
    rd_mux_o_s = 8'h00;
    for (int i = 0; i < NREGIONS; i++) begin
      rd_mux_e_s = rd_mux_e_s | (slv_read_data_even[8*i +: 8] & {8{sel_r == 2'(i)}});
      rd_mux_o_s = rd_mux_o_s | (slv_read_data_odd[8*i +: 8]  & {8{sel_r == 2'(i)}});
    end
  end

  assign read_data_even = rd_err_r ? 8'hff : rd_mux_e_s;
  assign read_data_odd  = rd_err_r ? 8'hff : rd_mux_o_s;

`ifdef BUSERR_EN
  logic bus_err_r;

  // Sticky unmapped-access flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_r <= 1'b0;
    end else if (accept_s && ((rd_act_s && !rd_map_s) || (wr_act_s && !wr_map_s))) begin
      bus_err_r <= 1'b1;
    end else begin
      bus_err_r <= bus_err_r;
    end
  end

  assign bus_error = bus_err_r;
`endif

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed scenarios plus randomized
// back-to-back accesses against a region/wait-state reference model.
`timescale 1ns/1ps
module tb_bus_interconnect;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_req;
  logic [14:0] read_addr_even, read_addr_odd, write_addr_even, write_addr_odd;
  logic        write_en_even, write_en_odd;
  logic [7:0]  write_data_even, write_data_odd;
  logic [7:0]  read_data_even, read_data_odd;
  logic        stall;
  logic [3:0]  slv_write_en_even, slv_write_en_odd;
  logic [31:0] slv_read_data_even, slv_read_data_odd;
`ifdef BUSERR_EN
  logic        bus_error;
`endif

  logic [7:0] sd_e [4];
  logic [7:0] sd_o [4];
  assign slv_read_data_even = {sd_e[3], sd_e[2], sd_e[1], sd_e[0]};
  assign slv_read_data_odd  = {sd_o[3], sd_o[2], sd_o[1], sd_o[0]};

  bus_interconnect dut (
    .clk(clk), .reset(reset), .read_req(read_req),
    .read_addr_even(read_addr_even), .read_addr_odd(read_addr_odd),
    .write_addr_even(write_addr_even), .write_addr_odd(write_addr_odd),
    .write_en_even(write_en_even), .write_en_odd(write_en_odd),
    .write_data_even(write_data_even), .write_data_odd(write_data_odd),
    .read_data_even(read_data_even), .read_data_odd(read_data_odd),
    .stall(stall),
    .slv_write_en_even(slv_write_en_even), .slv_write_en_odd(slv_write_en_odd),
    .slv_read_data_even(slv_read_data_even), .slv_read_data_odd(slv_read_data_odd)
`ifdef BUSERR_EN
    , .bus_error(bus_error)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit m_err = 1'b0;

  // Observations from the last run_access call.
  int         obs_stall;
  bit         obs_timeout;
  logic [3:0] obs_we_e, obs_we_o, obs_early_e, obs_early_o;
  logic [7:0] obs_rd_e, obs_rd_o;
  logic       obs_err;

  // ---------------- reference model ----------------
  function automatic int m_region(input logic [14:0] a);
    int r = 0;
    if (a >= 15'h0800) r = 1;
    if (a >= 15'h1000) r = 2;
    if (a >= 15'h1800) r = 3;
    return r;
  endfunction

  function automatic int m_ws(input int r);
    int tbl [4] = '{0, 0, 1, 2};
    return tbl[r];
  endfunction

  function automatic bit m_mapped(input logic [14:0] a);
`ifdef BUSERR_EN
    return a < 15'h3000;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_cost(input bit rd, input logic [14:0] ra, input bit wr, input logic [14:0] wa);
    int w = 0;
    if (rd && m_mapped(ra)) w = m_ws(m_region(ra));
    if (wr && m_mapped(wa) && m_ws(m_region(wa)) > w) w = m_ws(m_region(wa));
    return w;
  endfunction

  function automatic logic [3:0] m_we(input bit lane_we, input logic [14:0] wa);
    logic [3:0] v = 4'b0000;
    if (lane_we && m_mapped(wa)) v[m_region(wa)] = 1'b1;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_bus(input bit rd, input logic [14:0] ra, input bit we_e, input bit we_o, input logic [14:0] wa);
    read_req = rd; read_addr_odd = ra; read_addr_even = ra;
    write_en_even = we_e; write_en_odd = we_o;
    write_addr_odd = wa; write_addr_even = wa;
  endtask

  task automatic rand_slaves();
    for (int i = 0; i < 4; i++) begin
      sd_e[i] = 8'($urandom);
      sd_o[i] = 8'($urandom);
    end
  endtask

  task automatic pulse_reset();
    set_bus(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_err = 1'b0;
  endtask

  // Presents one access and holds it until stall drops (bounded); records what was seen.
  task automatic run_access(input bit rd, input logic [14:0] ra, input bit we_e, input bit we_o, input logic [14:0] wa);
    set_bus(rd, ra, we_e, we_o, wa);
    obs_stall = 0; obs_timeout = 1'b0;
    obs_early_e = 4'b0000; obs_early_o = 4'b0000;
    obs_we_e = 4'b0000; obs_we_o = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        obs_rd_e = read_data_even;
        obs_rd_o = read_data_odd;
`ifdef BUSERR_EN
        obs_err = bus_error;
`else
        obs_err = 1'b0;
`endif
      end
      if (stall === 1'b1) begin
        obs_stall++;
        obs_early_e |= slv_write_en_even;
        obs_early_o |= slv_write_en_odd;
        @(posedge clk); #1;
      end else begin
        obs_we_e = slv_write_en_even;
        obs_we_o = slv_write_en_odd;
        @(posedge clk); #1;
        return;
      end
    end
    obs_timeout = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rand_slaves();
    reset = 1'b1;
    @(posedge clk); #1;
    set_bus(1'b0, 15'h0000, 1'b0, 1'b1, 15'h0900);
    @(negedge clk);
    checks++;
    if (slv_write_en_odd !== 4'b0000 || slv_write_en_even !== 4'b0000) begin
      errors++; $display("FAIL reset_no_write: got %b/%b expected 0000/0000", slv_write_en_even, slv_write_en_odd);
    end
    @(posedge clk); #1;
    reset = 1'b0; m_err = 1'b0;
    run_access(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    checks++;
    if (obs_stall != 0 || obs_timeout) begin
      errors++; $display("FAIL reset_stall: got %0d cycles expected 0", obs_stall);
    end
    checks++;
    if (obs_rd_e !== sd_e[0] || obs_rd_o !== sd_o[0]) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected %h/%h", obs_rd_e, obs_rd_o, sd_e[0], sd_o[0]);
    end
`ifdef BUSERR_EN
    checks++;
    if (obs_err !== 1'b0) begin
      errors++; $display("FAIL reset_buserr: got %b expected 0", obs_err);
    end
`endif
  endtask

  task automatic test_write_ws0();
    write_data_odd = 8'h5a;
    run_access(1'b0, 15'h0000, 1'b0, 1'b1, 15'h0900);
    checks++;
    if (obs_stall != 0 || obs_timeout) begin
      errors++; $display("FAIL wr0_stall: got %0d expected 0", obs_stall);
    end
    checks++;
    if (obs_we_o !== 4'b0010 || obs_we_e !== 4'b0000) begin
      errors++; $display("FAIL wr0_enable: got %b/%b expected 0000/0010", obs_we_e, obs_we_o);
    end
    run_access(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    checks++;
    if (obs_we_o !== 4'b0000) begin
      errors++; $display("FAIL wr0_pulse_len: got %b expected 0000", obs_we_o);
    end
  endtask

  task automatic test_read_ws1();
    rand_slaves();
    run_access(1'b1, 15'h1000, 1'b0, 1'b0, 15'h0000);
    checks++;
    if (obs_stall != 1 || obs_timeout) begin
      errors++; $display("FAIL rd1_stall: got %0d expected 1", obs_stall);
    end
    run_access(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    checks++;
    if (obs_rd_e !== sd_e[2] || obs_rd_o !== sd_o[2]) begin
      errors++; $display("FAIL rd1_data: got %h/%h expected %h/%h", obs_rd_e, obs_rd_o, sd_e[2], sd_o[2]);
    end
  endtask

  task automatic test_write_ws2();
    write_data_even = 8'hc3;
    run_access(1'b0, 15'h0000, 1'b1, 1'b0, 15'h1800);
    checks++;
    if (obs_stall != 2 || obs_timeout) begin
      errors++; $display("FAIL wr2_stall: got %0d expected 2", obs_stall);
    end
    checks++;
    if (obs_we_e !== 4'b1000 || obs_early_e !== 4'b0000) begin
      errors++; $display("FAIL wr2_enable: got %b early %b expected 1000 early 0000", obs_we_e, obs_early_e);
    end
  endtask

  task automatic test_read_write_mixed();
    rand_slaves();
    run_access(1'b1, 15'h1000, 1'b0, 1'b1, 15'h1800);
    checks++;
    if (obs_stall != 2 || obs_timeout) begin
      errors++; $display("FAIL mix_stall: got %0d expected 2", obs_stall);
    end
    checks++;
    if (obs_we_o !== 4'b1000 || obs_we_e !== 4'b0000) begin
      errors++; $display("FAIL mix_enable: got %b/%b expected 0000/1000", obs_we_e, obs_we_o);
    end
    run_access(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    checks++;
    if (obs_rd_e !== sd_e[2] || obs_rd_o !== sd_o[2]) begin
      errors++; $display("FAIL mix_rdata: got %h/%h expected %h/%h", obs_rd_e, obs_rd_o, sd_e[2], sd_o[2]);
    end
  endtask

  task automatic test_reset_mid_wait();
    rand_slaves();
    set_bus(1'b1, 15'h1000, 1'b0, 1'b1, 15'h1800);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL rmw_stall1: got %b expected 1", stall);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (slv_write_en_even !== 4'b0000 || slv_write_en_odd !== 4'b0000) begin
      errors++; $display("FAIL rmw_no_write: got %b/%b expected 0000/0000", slv_write_en_even, slv_write_en_odd);
    end
    @(posedge clk); #1;
    reset = 1'b0; m_err = 1'b0;
    set_bus(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || slv_write_en_odd !== 4'b0000) begin
      errors++; $display("FAIL rmw_after: got stall %b we %b expected 0 0000", stall, slv_write_en_odd);
    end
    checks++;
    if (read_data_even !== sd_e[0] || read_data_odd !== sd_o[0]) begin
      errors++; $display("FAIL rmw_rdata: got %h/%h expected %h/%h", read_data_even, read_data_odd, sd_e[0], sd_o[0]);
    end
    @(posedge clk); #1;
  endtask

`ifdef BUSERR_EN
  task automatic test_buserr();
    pulse_reset();
    run_access(1'b1, 15'h3000, 1'b0, 1'b0, 15'h0000);
    checks++;
    if (obs_stall != 0 || obs_err !== 1'b0) begin
      errors++; $display("FAIL be_read: got stall %0d err %b expected 0 0", obs_stall, obs_err);
    end
    run_access(1'b0, 15'h0000, 1'b0, 1'b1, 15'h3000);
    checks++;
    if (obs_rd_e !== 8'hff || obs_rd_o !== 8'hff || obs_err !== 1'b1) begin
      errors++; $display("FAIL be_rdata: got %h/%h err %b expected ff/ff 1", obs_rd_e, obs_rd_o, obs_err);
    end
    checks++;
    if (obs_we_o !== 4'b0000 || obs_stall != 0) begin
      errors++; $display("FAIL be_write: got we %b stall %0d expected 0000 0", obs_we_o, obs_stall);
    end
    repeat (3) run_access(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    checks++;
    if (obs_err !== 1'b1) begin
      errors++; $display("FAIL be_sticky: got %b expected 1", obs_err);
    end
    pulse_reset();
    run_access(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    checks++;
    if (obs_err !== 1'b0) begin
      errors++; $display("FAIL be_clear: got %b expected 0", obs_err);
    end
  endtask
`endif

  task automatic test_back_to_back();
    bit          rd, we_e, we_o, prev_rd, prev_map;
    int          prev_reg, exp_ws;
    logic [14:0] ra, wa;
    logic [7:0]  exp_e, exp_o;
    pulse_reset();
    prev_rd = 1'b0; prev_map = 1'b1; prev_reg = 0;
    for (int n = 0; n < 60; n++) begin
      rd   = 1'($urandom);
      we_e = 1'($urandom);
      we_o = 1'($urandom);
      ra   = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15'h1fff));
      wa   = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15'h1fff));
      write_data_even = 8'($urandom);
      write_data_odd  = 8'($urandom);
      rand_slaves();
      exp_ws = m_cost(rd, ra, we_e | we_o, wa);
      run_access(rd, ra, we_e, we_o, wa);
      checks++;
      if (obs_timeout || obs_stall != exp_ws) begin
        errors++; $display("FAIL b2b_stall[%0d]: got %0d timeout %b expected %0d", n, obs_stall, obs_timeout, exp_ws);
      end
      checks++;
      if (obs_we_e !== m_we(we_e, wa) || obs_we_o !== m_we(we_o, wa) || obs_early_e !== 4'b0000 || obs_early_o !== 4'b0000) begin
        errors++; $display("FAIL b2b_we[%0d]: got %b/%b early %b/%b expected %b/%b", n, obs_we_e, obs_we_o,
                           obs_early_e, obs_early_o, m_we(we_e, wa), m_we(we_o, wa));
      end
      if (prev_rd) begin
        exp_e = prev_map ? sd_e[prev_reg] : 8'hff;
        exp_o = prev_map ? sd_o[prev_reg] : 8'hff;
        checks++;
        if (obs_rd_e !== exp_e || obs_rd_o !== exp_o) begin
          errors++; $display("FAIL b2b_rdata[%0d]: got %h/%h expected %h/%h", n, obs_rd_e, obs_rd_o, exp_e, exp_o);
        end
      end
`ifdef BUSERR_EN
      checks++;
      if (obs_err !== m_err) begin
        errors++; $display("FAIL b2b_buserr[%0d]: got %b expected %b", n, obs_err, m_err);
      end
      if ((rd && !m_mapped(ra)) || ((we_e || we_o) && !m_mapped(wa))) m_err = 1'b1;
`endif
      prev_rd = rd; prev_map = m_mapped(ra); prev_reg = m_region(ra);
    end
  endtask

  initial begin
    reset = 1'b1;
    write_data_even = 8'h00; write_data_odd = 8'h00;
    set_bus(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000);
    for (int i = 0; i < 4; i++) begin sd_e[i] = 8'h00; sd_o[i] = 8'h00; end
    test_reset();
    test_write_ws0();
    test_read_ws1();
    test_write_ws2();
    test_read_write_mixed();
    test_reset_mid_wait();
`ifdef BUSERR_EN
    test_buserr();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
